// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between the
// CPU memory path and the program-loader/debug port. One access is issued
// per deciding cycle; the owner sees a one-cycle ready pulse carrying read
// data on the following cycle, and the CPU is stalled while it waits.
module mem_port_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  output logic          cpu_stall,
  input  logic          ld_req,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_wdata,
  output logic [DW-1:0] ld_rdata,
  output logic          ld_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_RSP = 2'd1,
    LD_RSP  = 2'd2
  } state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_LD  = 1'b1;

  state_t state;
  state_t next_state;
  logic   last_owner;
  logic   rsp_we;
  logic   grant_cpu;
  logic   grant_ld;

  // Decide the winner, drive the memory port and the response side; all outputs forced low in reset
  always_comb begin
    next_state = IDLE;
    grant_cpu  = 1'b0;
    grant_ld   = 1'b0;
    cpu_ready  = 1'b0;
    cpu_rdata  = '0;
    ld_ready   = 1'b0;
    ld_rdata   = '0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    cpu_stall  = 1'b0;

    case (state)
      IDLE: begin
        if (cpu_req && (!ld_req || last_owner == OWNER_LD)) begin
          grant_cpu = 1'b1;
        end else if (ld_req) begin
          grant_ld = 1'b1;
        end
      end
      CPU_RSP: begin
        cpu_ready = 1'b1;
        cpu_rdata = rsp_we ? '0 : mem_rdata;
        if (ld_req) begin
          grant_ld = 1'b1;
        end
      end
      LD_RSP: begin
        ld_ready = 1'b1;
        ld_rdata = rsp_we ? '0 : mem_rdata;
        if (cpu_req) begin
          grant_cpu = 1'b1;
        end
      end
      default: begin
      end
    endcase

    if (grant_cpu) begin
      mem_en     = 1'b1;
      mem_we     = cpu_we;
      mem_addr   = cpu_addr;
      mem_wdata  = cpu_wdata;
      next_state = CPU_RSP;
    end else if (grant_ld) begin
      mem_en     = 1'b1;
      mem_we     = ld_we;
      mem_addr   = ld_addr;
      mem_wdata  = ld_wdata;
      next_state = LD_RSP;
    end

    if (!rst) begin
      next_state = IDLE;
      grant_cpu  = 1'b0;
      grant_ld   = 1'b0;
      cpu_ready  = 1'b0;
      cpu_rdata  = '0;
      ld_ready   = 1'b0;
      ld_rdata   = '0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
    end

    cpu_stall = rst & cpu_req & ~cpu_ready;
  end

  // State register plus the owner/write-type of the access now in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_owner <= OWNER_LD;
      rsp_we     <= 1'b0;
    end else begin
      state <= next_state;
      if (grant_cpu) begin
        last_owner <= OWNER_CPU;
        rsp_we     <= cpu_we;
      end else if (grant_ld) begin
        last_owner <= OWNER_LD;
        rsp_we     <= ld_we;
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the single-port unified instruction/data memory of the multicycle core between the CPU memory path (fetch, load, store) and the program-loader/debug port. Grants one access at a time, drives the memory port, returns read data with a one-cycle `ready` pulse, and raises `cpu_stall` to freeze the CPU controller's state register while its access is outstanding.

## Interface
- `AW`, 16, address width (word address)
- `DW`, 16, data word width

- `clk`  in  1  clock; all state changes on the rising edge
- `rst`  in  1  reset; synchronous, active-low
- `cpu_req`  in  1  CPU access request; held until `cpu_ready`
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  AW  CPU address
- `cpu_wdata`  in  DW  CPU write data
- `cpu_rdata`  out  DW  read data, valid while `cpu_ready` for reads
- `cpu_ready`  out  1  one-cycle completion pulse
- `cpu_stall`  out  1  `cpu_req & ~cpu_ready`
- `ld_req`, `ld_we`, `ld_addr`, `ld_wdata`, `ld_rdata`, `ld_ready`  same widths and rules as the CPU set, for the loader
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  synchronous read data, valid the cycle after `mem_en` with `mem_we=0`

## Operation
- States: IDLE, CPU_RSP, LD_RSP. Registers: state, `last_owner` (CPU/LD), `rsp_we`.
- Issue is combinational in the deciding cycle: winner's addr/wdata/we drive `mem_*`, `mem_en=1`, next state = winner's RSP, `last_owner` <= winner, `rsp_we` <= winner's we.
- IDLE: only one requesting -> grant it. Both -> grant the one that is not `last_owner`. None -> stay IDLE, `mem_en=0`.
- CPU_RSP: `cpu_ready=1`; `cpu_rdata = mem_rdata` if `rsp_we=0`, else 0. Same cycle, if `ld_req` -> issue loader access, next LD_RSP; else next IDLE. The CPU is never re-granted from CPU_RSP (its `req` still reflects the completed access).
- LD_RSP: mirror image with roles swapped.
- Outside its own RSP state each `*_ready=0` and `*_rdata=0`.
- `mem_addr`/`mem_wdata`/`mem_we` are 0 whenever `mem_en=0`.
- Requester rules: hold `req`, `we`, `addr`, `wdata` stable from assertion through the `ready` cycle; `req` may be reasserted for a new access from the cycle after `ready`. A `req` dropped after issue does not cancel the access; `ready` still pulses.

## Timing
- Reset (`rst=0` at an edge): state IDLE, `last_owner`=LD (CPU wins the first tie), `rsp_we`=0. While `rst=0`, all outputs are 0: `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, both `ready`, both `rdata`, `cpu_stall`.
- Latency: request seen in IDLE at cycle N -> `mem_en` at N -> `ready` at N+1. Lone requester: one access per 2 cycles.
- Both continuously requesting: alternate CPU, LD, CPU, ... one access per cycle (`mem_en` continuously high).
- Request arriving in the other requester's RSP cycle: issued that cycle, `ready` next cycle.
- Writes commit at the issue-cycle edge; `ready` follows at N+1 with `rdata=0`.
- Reset asserted in an RSP state: no `ready` pulse is produced; a write issued before reset remains committed.
- `cpu_stall` is combinational: high from the cycle `cpu_req` rises through the cycle before `cpu_ready`; low in the `cpu_ready` cycle.

## Test plan
- Reset: hold `rst=0` 3 cycles with both `req=1` -> all outputs 0. Release with both `req` high -> CPU granted first (`mem_addr=cpu_addr`).
- CPU read alone: `cpu_addr=0x0010`, memory holds 0xBEEF -> `mem_en` at N, `cpu_ready=1` and `cpu_rdata=0xBEEF` at N+1, `cpu_stall` high only at N.
- Loader write then CPU read: loader writes 0x1234 to 0x0020; then CPU reads 0x0020 -> `ld_ready` pulses with `ld_rdata=0`, and the CPU read returns 0x1234.
- Contention: both request continuously for 8 cycles -> `mem_en` high every cycle, owners alternate C,L,C,L; each sees 4 `ready` pulses, none in consecutive cycles.
- Mid-RSP arrival: CPU issued at N, `ld_req` rises at N+1 -> `mem_addr=ld_addr` at N+1, `ld_ready` at N+2.
- Reset mid-access: assert `rst=0` in CPU_RSP -> no `cpu_ready` on the next cycle, state IDLE; a previously issued write is visible on a later read.
